// File: rtl/hssl_tx_link_ctrl.sv
// rtl/hssl_tx_link_ctrl.sv - HSSL transmit link controller (comma, handshake, run, clock correction)
module hssl_tx_link_ctrl #(
  parameter int         CLKC_PERIOD   = 1024,
  parameter int         CLKC_LEN      = 2,
  parameter int         HSK_MIN_WORDS = 16,
  parameter logic [7:0] VERSION       = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        local_sync_in,
  input  logic        hsk_rcvd_in,
  input  logic [15:0] idso_in,
  input  logic        stop_in,
  input  logic [31:0] txdata_in,
  input  logic [3:0]  txcharisk_in,
  input  logic        txvld_in,
  output logic        txrdy_out,
  output logic [31:0] tx_data_out,
  output logic [3:0]  tx_charisk_out,
  output logic [1:0]  state_out,
  output logic        handshake_phase_out,
  output logic        handshake_complete_out
);

  localparam int CCW = $clog2(CLKC_PERIOD);
  localparam int HCW = $clog2(HSK_MIN_WORDS + 1);

  localparam logic [CCW-1:0] CC_LAST = CCW'(CLKC_PERIOD - 1);
  localparam logic [CCW-1:0] CC_LEN  = CCW'(CLKC_LEN);
  localparam logic [HCW-1:0] HSK_MIN = HCW'(HSK_MIN_WORDS);

  localparam logic [1:0] ST_COMMA     = 2'b10;
  localparam logic [1:0] ST_HANDSHAKE = 2'b01;
  localparam logic [1:0] ST_RUN       = 2'b00;

  localparam logic [31:0] IDLE_WORD = 32'h5050_50BC;
  localparam logic [3:0]  IDLE_K    = 4'b0001;
  localparam logic [31:0] CLKC_WORD = 32'hF7F7_F7F7;
  localparam logic [3:0]  CLKC_K    = 4'b1111;
  localparam logic [3:0]  HSK_K     = 4'b0001;

  logic [1:0]     state;
  logic [1:0]     next_state;
  logic [CCW-1:0] cc;
  logic [HCW-1:0] hsk_cnt;
  logic           clkc_slot;
  logic           xfer;
  logic           hsk_load;

  assign clkc_slot = (cc < CC_LEN);
  assign txrdy_out = (state == ST_RUN) && !stop_in && !clkc_slot;
  assign xfer      = txvld_in && txrdy_out;
  assign state_out = state;

  // An HSK word is only sent while staying in handshake, so the leaving cycle
  // never emits an extra one beyond the counted minimum.
  assign hsk_load  = (state == ST_HANDSHAKE) && (next_state == ST_HANDSHAKE) && !clkc_slot;

  // Next-state logic; loss of sync always wins, 2'b11 recovers to COMMA.
  always_comb begin
    next_state = ST_COMMA;
    case (state)
      ST_COMMA:     next_state = local_sync_in ? ST_HANDSHAKE : ST_COMMA;
      ST_HANDSHAKE: begin
        if (!local_sync_in)
          next_state = ST_COMMA;
        else if ((hsk_cnt == HSK_MIN) && hsk_rcvd_in)
          next_state = ST_RUN;
        else
          next_state = ST_HANDSHAKE;
      end
      ST_RUN:       next_state = local_sync_in ? ST_RUN : ST_COMMA;
      default:      next_state = ST_COMMA;
    endcase
  end

  // Free-running clock-correction slot counter.
  always_ff @(posedge clk) begin
    if (!reset)
      cc <= '0;
    else if (cc == CC_LAST)
      cc <= '0;
    else
      cc <= cc + 1'b1;
  end

  // State register with registered next-state status decodes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                  <= ST_COMMA;
      handshake_phase_out    <= 1'b0;
      handshake_complete_out <= 1'b0;
    end else begin
      state                  <= next_state;
      handshake_phase_out    <= (next_state == ST_HANDSHAKE);
      handshake_complete_out <= (next_state == ST_RUN);
    end
  end

  // Count handshake words sent, saturating at the minimum; cleared outside handshake.
  always_ff @(posedge clk) begin
    if (!reset)
      hsk_cnt <= '0;
    else if (state != ST_HANDSHAKE)
      hsk_cnt <= '0;
    else if (hsk_load && (hsk_cnt != HSK_MIN))
      hsk_cnt <= hsk_cnt + 1'b1;
  end

  // Output word select: clock correction, then accepted frame word, then state word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_data_out    <= IDLE_WORD;
      tx_charisk_out <= IDLE_K;
    end else if (clkc_slot) begin
      tx_data_out    <= CLKC_WORD;
      tx_charisk_out <= CLKC_K;
    end else if (xfer) begin
      tx_data_out    <= txdata_in;
      tx_charisk_out <= txcharisk_in;
    end else if (hsk_load) begin
      tx_data_out    <= {idso_in, VERSION, 8'h7C};
      tx_charisk_out <= HSK_K;
    end else begin
      tx_data_out    <= IDLE_WORD;
      tx_charisk_out <= IDLE_K;
    end
  end

endmodule

// File: tb/tb_hssl_tx_link_ctrl.sv
// tb/tb_hssl_tx_link_ctrl.sv - randomized self-checking bench for hssl_tx_link_ctrl
module tb_hssl_tx_link_ctrl;

  localparam int PERIOD = 1024;
  localparam int LEN    = 2;
  localparam int HMIN   = 16;
  localparam logic [31:0] IDLE_W = 32'h5050_50BC;
  localparam logic [31:0] CLKC_W = 32'hF7F7_F7F7;

  localparam int S_COMMA = 0;
  localparam int S_HSK   = 1;
  localparam int S_RUN   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        local_sync_in = 1'b0;
  logic        hsk_rcvd_in = 1'b0;
  logic [15:0] idso_in = 16'hDEAD;
  logic        stop_in = 1'b0;
  logic [31:0] txdata_in = '0;
  logic [3:0]  txcharisk_in = '0;
  logic        txvld_in = 1'b0;
  logic        txrdy_out;
  logic [31:0] tx_data_out;
  logic [3:0]  tx_charisk_out;
  logic [1:0]  state_out;
  logic        handshake_phase_out;
  logic        handshake_complete_out;

  hssl_tx_link_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .local_sync_in          (local_sync_in),
    .hsk_rcvd_in            (hsk_rcvd_in),
    .idso_in                (idso_in),
    .stop_in                (stop_in),
    .txdata_in              (txdata_in),
    .txcharisk_in           (txcharisk_in),
    .txvld_in               (txvld_in),
    .txrdy_out              (txrdy_out),
    .tx_data_out            (tx_data_out),
    .tx_charisk_out         (tx_charisk_out),
    .state_out              (state_out),
    .handshake_phase_out    (handshake_phase_out),
    .handshake_complete_out (handshake_complete_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: link phase, cycles since reset release, handshake words sent.
  int          m_state;
  int          m_t;
  int          m_h;
  bit          m_init = 1'b0;
  bit          m_xfer;
  logic [31:0] e_data;
  logic [3:0]  e_k;
  bit          e_hp, e_hc;
  logic [31:0] sb[$];
  int          n_hsk, n_clkc, n_data, n_acc;

  function automatic logic [1:0] enc(input int s);
    case (s)
      S_COMMA: return 2'b10;
      S_HSK:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic step();
    bit slot, rdy;
    int nxt;
    #2;
    slot   = m_init && ((m_t % PERIOD) < LEN);
    rdy    = m_init && (m_state == S_RUN) && !stop_in && !slot;
    m_xfer = 1'b0;
    if (m_init && reset) check("txrdy", 64'(txrdy_out), 64'(rdy));
    if (!reset) begin
      m_init = 1'b1; m_state = S_COMMA; m_t = 0; m_h = 0;
      e_data = IDLE_W; e_k = 4'b0001; e_hp = 1'b0; e_hc = 1'b0;
      sb.delete();
    end else if (m_init) begin
      m_xfer = rdy && txvld_in;
      nxt = m_state;
      if (m_state == S_COMMA && local_sync_in) nxt = S_HSK;
      else if (m_state == S_HSK && !local_sync_in) nxt = S_COMMA;
      else if (m_state == S_HSK && m_h >= HMIN && hsk_rcvd_in) nxt = S_RUN;
      else if (m_state == S_RUN && !local_sync_in) nxt = S_COMMA;
      if (slot) begin
        e_data = CLKC_W; e_k = 4'b1111;
      end else if (m_xfer) begin
        e_data = txdata_in; e_k = txcharisk_in;
        sb.push_back(txdata_in);
        n_acc++;
      end else if (m_state == S_HSK && nxt == S_HSK) begin
        e_data = {idso_in, 8'h01, 8'h7C}; e_k = 4'b0001;
      end else begin
        e_data = IDLE_W; e_k = 4'b0001;
      end
      if (m_state != S_HSK) m_h = 0;
      else if (nxt == S_HSK && !slot && m_h < HMIN) m_h++;
      e_hp = (nxt == S_HSK);
      e_hc = (nxt == S_RUN);
      m_state = nxt;
      m_t++;
    end
    @(posedge clk);
    #1;
    if (m_init) begin
      check("tx_word", 64'({tx_charisk_out, tx_data_out}), 64'({e_k, e_data}));
      check("state", 64'(state_out), 64'(enc(m_state)));
      check("status", 64'({handshake_phase_out, handshake_complete_out}), 64'({e_hp, e_hc}));
      if (tx_charisk_out == 4'b1111) n_clkc++;
      if (tx_charisk_out == 4'b0001 && tx_data_out[7:0] == 8'h7C) n_hsk++;
      if (tx_charisk_out == 4'b0000) begin
        n_data++;
        if (sb.size() == 0) check("sb_extra", 64'(1), 64'(0));
        else check("sb_order", 64'(tx_data_out), 64'(sb.pop_front()));
      end
    end
  endtask

  int idx = 0;

  task automatic handshake_to_run(input string tag);
    int guard;
    n_hsk = 0;
    guard = 0;
    local_sync_in = 1'b1;
    hsk_rcvd_in = 1'b1;
    txvld_in = 1'b0;
    while (m_state != S_RUN && guard < 200) begin
      step();
      guard++;
    end
    check({tag, "_timeout"}, 64'(guard < 200), 64'(1));
    check({tag, "_hsk_words"}, 64'(n_hsk), 64'(HMIN));
    check({tag, "_complete"}, 64'(handshake_complete_out), 64'(1));
  endtask

  task automatic stream_cycle(input int stop_pct, input int vld_pct);
    stop_in = ($urandom_range(0, 99) < stop_pct);
    txvld_in = ($urandom_range(0, 99) < vld_pct);
    txdata_in = idx;
    txcharisk_in = 4'b0000;
    step();
    if (m_xfer) idx++;
  endtask

  initial begin
    int guard;
    // Reset held
    for (int i = 0; i < 3; i++) step();
    check("rst_state", 64'(state_out), 64'(2'b10));
    check("rst_word", 64'({tx_charisk_out, tx_data_out}), 64'({4'b0001, IDLE_W}));

    // Comma phase
    reset = 1'b1;
    n_clkc = 0;
    for (int i = 0; i < 20; i++) step();
    check("comma_clkc_cnt", 64'(n_clkc), 64'(2));
    check("comma_rdy", 64'(txrdy_out), 64'(0));

    // First handshake
    idso_in = 16'hDEAD;
    handshake_to_run("hsk1");

    // 100 words with random stop
    guard = 0;
    while (idx < 100 && guard < 600) begin
      stream_cycle(30, 100);
      guard++;
    end
    check("stream100", 64'(idx), 64'(100));

    // Long random run across the clock-correction wrap
    n_clkc = 0;
    for (int i = 0; i < 1200; i++) stream_cycle(20, 80);
    check("wrap_clkc_cnt", 64'(n_clkc), 64'(2));

    // Drop sync with a word offered
    guard = 0;
    while (((m_t % PERIOD) < LEN) && guard < 10) begin
      stream_cycle(0, 0);
      guard++;
    end
    stop_in = 1'b0;
    txvld_in = 1'b1;
    txdata_in = idx;
    local_sync_in = 1'b0;
    step();
    if (m_xfer) idx++;
    check("drop_rdy", 64'(txrdy_out), 64'(0));
    check("drop_state", 64'(state_out), 64'(2'b10));
    for (int i = 0; i < 5; i++) step();
    txvld_in = 1'b0;

    // Re-sync
    idso_in = 16'h1234;
    handshake_to_run("hsk2");

    // Reset mid-handshake
    local_sync_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    local_sync_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_hsk", 64'(handshake_phase_out), 64'(1));
    reset = 1'b0;
    step();
    check("rst_hsk_state", 64'(state_out), 64'(2'b10));
    check("rst_hsk_status", 64'({handshake_phase_out, handshake_complete_out}), 64'(0));
    reset = 1'b1;
    n_clkc = 0;
    for (int i = 0; i < 4; i++) step();
    check("rst_hsk_clkc", 64'(n_clkc), 64'(2));

    // Reset during a clock-correction slot
    guard = 0;
    while ((m_t % PERIOD) != 0 && guard < 1100) begin
      stream_cycle(10, 70);
      guard++;
    end
    check("slot_reach", 64'(guard < 1100), 64'(1));
    reset = 1'b0;
    step();
    check("rst_slot_word", 64'({tx_charisk_out, tx_data_out}), 64'({4'b0001, IDLE_W}));
    reset = 1'b1;
    txvld_in = 1'b0;
    n_clkc = 0;
    for (int i = 0; i < 4; i++) step();
    check("rst_slot_clkc", 64'(n_clkc), 64'(2));

    check("no_loss", 64'(n_data), 64'(n_acc));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hssl_tx_link_ctrl.md
Name: hssl_tx_link_ctrl

Overview:
- Transmit-side link controller for the HSSL transceiver.
- Drives the 32-bit 8b/10b TX word stream to the remote end. It sends comma/idle words so the remote receiver can acquire sync, then sends handshake words carrying the local ID and version. It then forwards spiNNlink frame words from the multiplexer.
- A periodic clock-correction burst is inserted in every state.
- Sits between the spiNNlink frame assembler/transmitter and the transceiver TX port. It uses local RX sync status and remote-handshake status from the receive side.

Parameters:
- CLKC_PERIOD, 1024, cycles between the starts of consecutive clock-correction bursts (≥ CLKC_LEN+2).
- CLKC_LEN, 2, clock-correction words per burst (≥1).
- HSK_MIN_WORDS, 16, minimum handshake words sent before leaving handshake.
- VERSION, 8'h01, protocol version placed in handshake words.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- local_sync_in  in  1  local RX loss-of-sync state machine is in SYNC_ACQUIRED.
- hsk_rcvd_in  in  1  valid remote handshake word received.
- idso_in  in  16  local link ID sent in handshake.
- stop_in  in  1  suppress frame forwarding (idle only).
- txdata_in  in  32  frame word from transmitter.
- txcharisk_in  in  4  K-char flags for txdata_in.
- txvld_in  in  1  frame word valid.
- txrdy_out  out  1  frame word accepted this cycle if txvld_in.
- tx_data_out  out  32  transceiver TX data.
- tx_charisk_out  out  4  transceiver TX K-char flags.
- state_out  out  2  link state.
- handshake_phase_out  out  1  in HANDSHAKE state.
- handshake_complete_out  out  1  in RUN state.

Behaviour:

Word definitions:
- IDLE: 32'h5050_50BC, charisk 4'b0001 (K28.5 in byte 0).
- CLKC: 32'hF7F7_F7F7, charisk 4'b1111.
- HSK: {idso_in, VERSION, 8'h7C}, charisk 4'b0001 (K28.3 in byte 0).

States (state_out encoding):
- COMMA = 2'b10.
- HANDSHAKE = 2'b01.
- RUN = 2'b00.
- 2'b11 is illegal and goes to COMMA next cycle.

Reset (reset==0 at a clk edge):
- state = COMMA; cc = 0; hsk_cnt = 0.
- tx_data_out = IDLE, tx_charisk_out = 4'b0001.
- handshake_phase_out = 0, handshake_complete_out = 0.
- Reset asserted mid-burst or mid-frame abandons all activity immediately. No partial word completes.

Clock-correction counter cc:
- Width $clog2(CLKC_PERIOD).
- Increments every cycle; wraps to 0 after CLKC_PERIOD-1.
- A cycle is a CLKC slot when the current cc < CLKC_LEN.

tx_data_out / tx_charisk_out:
- Both are registered and updated every edge.
- Priority: reset > CLKC slot > state word.
- COMMA: IDLE.
- HANDSHAKE: HSK.
- RUN with transfer: txdata_in/txcharisk_in.
- RUN without transfer: IDLE.
- Latency from accepted frame word to TX output is 1 cycle.

Handshake and transfer:
- txrdy_out is combinational: (state==RUN) && !stop_in && (cc >= CLKC_LEN).
- A transfer occurs when txvld_in && txrdy_out. Nothing is dropped or duplicated.
- txvld_in is never required to wait on txrdy_out.

hsk_cnt:
- Increments on each HSK word actually loaded (non-CLKC-slot cycle in HANDSHAKE).
- Saturates at HSK_MIN_WORDS.
- Cleared in COMMA and RUN.

Transitions (evaluated every edge):
- COMMA → HANDSHAKE when local_sync_in==1.
- HANDSHAKE → COMMA when local_sync_in==0; this takes precedence.
- HANDSHAKE → RUN when hsk_cnt==HSK_MIN_WORDS && hsk_rcvd_in.
- RUN → COMMA when local_sync_in==0. txrdy_out drops in the next cycle. An accepted word in the same cycle is still output.

Status outputs:
- handshake_phase_out and handshake_complete_out are registered decodes of the next state. They change in the same edge as state.

Simultaneous events:
- A CLKC slot overrides a state transition's output word but not the transition itself.
- stop_in has no effect outside RUN.

Test Plan:
- Release reset, local_sync_in=0 for 20 cycles: first 2 outputs CLKC (32'hF7F7F7F7/4'b1111), then IDLE 32'h505050BC/4'b0001; state_out=2'b10; txrdy_out=0.
- Raise local_sync_in; hsk_rcvd_in=1 from cycle 0, idso_in=16'hDEAD: exactly 16 HSK words 32'hDEAD017C/4'b0001 output (excluding CLKC slots), then state_out=2'b00, handshake_complete_out=1.
- In RUN, stream 100 words 0..99 with txvld_in=1 and random stop_in: each accepted word appears on tx_data_out 1 cycle later in order; IDLE where no transfer; no loss or duplication.
- Run across cc wrap (CLKC_PERIOD=1024): exactly 2 CLKC words at each 1024-cycle boundary; txrdy_out=0 in those 2 cycles; the data stream resumes intact.
- Drop local_sync_in mid-stream: next state COMMA; txrdy_out=0 in the next cycle; IDLE output; hsk_cnt restarts, and 16 fresh HSK words are sent on the next sync.
- Assert reset=0 mid-HANDSHAKE and during a CLKC slot: next output is IDLE/4'b0001, state 2'b10, all status outputs 0, cc restarts with a CLKC burst.
